// File: rtl/fpga_pkg.sv
// Shared types and helpers for the fpga_exec program executor.
// - opcode_e / state_e : instruction set and FSM state encodings
// - instr_t            : decoded instruction, sized for the widest supported configuration
// - off_*              : bit offsets of each field inside a raw {op, t, ma, a, mb, b} word
// - decode             : splits a raw word into instr_t for a given Width / AW
package fpga_pkg;

  // Upper bounds for the decoded struct; a configuration must satisfy Width <= MaxW and
  // AW <= MaxAw.
  localparam int unsigned MaxW      = 32;
  localparam int unsigned MaxAw     = 16;
  localparam int unsigned OpW       = 4;
  localparam int unsigned InstrMaxW = OpW + MaxAw + 2 * (1 + MaxW);

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMov  = 4'd2,
    OpOut  = 4'd3,
    OpJmp  = 4'd4,
    OpJeq  = 4'd5,
    OpJlt  = 4'd6,
    OpHalt = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StExec,
    StStall,
    StDone
  } state_e;

  // op is kept as raw bits: codes 8..15 are legal and behave as NOP.
  typedef struct packed {
    logic [OpW-1:0]   op;
    logic [MaxAw-1:0] t;
    logic             ma;
    logic [MaxW-1:0]  a;
    logic             mb;
    logic [MaxW-1:0]  b;
  } instr_t;

  function automatic int unsigned off_mb(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned off_a(input int unsigned width);
    return width + 1;
  endfunction

  function automatic int unsigned off_ma(input int unsigned width);
    return 2 * width + 1;
  endfunction

  function automatic int unsigned off_t(input int unsigned width);
    return 2 * width + 2;
  endfunction

  function automatic int unsigned off_op(input int unsigned width, input int unsigned aw);
    return 2 * width + 2 + aw;
  endfunction

  function automatic instr_t decode(input logic [InstrMaxW-1:0] raw, input int unsigned aw,
                                    input int unsigned width);
    instr_t               r;
    logic [InstrMaxW-1:0] wmask;
    logic [InstrMaxW-1:0] amask;
    logic [InstrMaxW-1:0] one;
    one   = InstrMaxW'(1);
    wmask = (one << width) - one;
    amask = (one << aw) - one;
    r.b   = MaxW'(raw & wmask);
    r.mb  = |((raw >> off_mb(width)) & one);
    r.a   = MaxW'((raw >> off_a(width)) & wmask);
    r.ma  = |((raw >> off_ma(width)) & one);
    r.t   = MaxAw'((raw >> off_t(width)) & amask);
    r.op  = OpW'((raw >> off_op(width, aw)) & InstrMaxW'(4'hF));
    return r;
  endfunction

endpackage

// File: rtl/fpga_exec_if.sv
// Out-channel bundle of fpga_exec.
// - out_valid : head word available (producer -> consumer)
// - out_data  : head word
// - out_ready : consumer takes the head word when valid and ready are both high
interface fpga_exec_if #(
  parameter int unsigned Width = 12
) ();
  logic             out_valid;
  logic [Width-1:0] out_data;
  logic             out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fpga_out_fifo.sv
// Width x Depth ring buffer feeding the out channel.
// - clr_i               : synchronous flush (takes priority over push/pop)
// - push_i / wdata_i    : write one word; ignored while full_o
// - full_o              : no free slot this cycle (a same-cycle pop does not free one)
// - out_valid_o/data_o  : head word, data forced to zero while empty
// - out_ready_i         : pop the head when valid
module fpga_out_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o      = (cnt_q == (PW + 1)'(Depth));
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem[rd_q] : '0;
  assign do_push     = push_i & ~full_o & ~clr_i;
  assign do_pop      = out_valid_o & out_ready_i & ~clr_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; cnt_q alone decides what is visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpga_exec.sv
// Loadable-program executor: program memory, local data memory, 2-cycle FETCH/EXEC FSM,
// step budget and a buffered out channel.
// - clock / reset        : sole clock, asynchronous active-low reset
// - load/load_addr/_data : program write, honoured only in IDLE/DONE
// - run                  : start pulse, honoured only in IDLE/DONE
// - out_if               : out channel (valid/ready), drains in every state
// - finished/success/timeout : completion flags, held until the next run or reset
// - ip / steps           : instruction pointer and retired-instruction count
module fpga_exec
  import fpga_pkg::*;
#(
  parameter int unsigned Width    = 12,
  parameter int unsigned NLocal   = 64,
  parameter int unsigned NCode    = 64,
  parameter int unsigned NOut     = 16,
  parameter int unsigned MaxSteps = 1000,
  parameter int unsigned AW       = $clog2((NLocal > NCode) ? NLocal : NCode)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [AW-1:0]               load_addr,
  input  logic [4+AW+2*(1+Width)-1:0] load_data,
  input  logic                        run,
  fpga_exec_if.master                 out_if,
  output logic                        finished,
  output logic                        success,
  output logic                        timeout,
  output logic [AW-1:0]               ip,
  output logic [31:0]                 steps
);

  localparam int unsigned InstrW = 4 + AW + 2 * (1 + Width);

  function automatic logic [AW-1:0] wrap_local(input logic [AW-1:0] x);
    return AW'(32'(x) % NLocal);
  endfunction

  function automatic logic [AW-1:0] wrap_code(input logic [AW-1:0] x);
    return AW'(32'(x) % NCode);
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     ip_q, ip_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic [31:0]       steps_q, steps_d;
  logic              fin_q, fin_d, succ_q, succ_d, tmo_q, tmo_d;

  logic [InstrW-1:0] pmem [NCode];
  logic [Width-1:0]  lmem [NLocal];
  logic [InstrW-1:0] instr_q;

  instr_t            dec;
  logic              unused_dec;
  logic [Width-1:0]  imm_a, imm_b, val_a, val_b;

  logic              pmem_we;
  logic              lmem_we;
  logic [AW-1:0]     lmem_waddr;
  logic [Width-1:0]  lmem_wdata;
  logic              fifo_push, fifo_clr, fifo_full;
  logic              retire, jump, halt;
  logic [AW:0]       next_ip;

  assign dec        = decode(InstrMaxW'(instr_q), AW, Width);
  assign unused_dec = ^dec;
  assign imm_a      = dec.a[Width-1:0];
  assign imm_b      = dec.b[Width-1:0];
  assign val_a      = dec.ma ? lmem[wrap_local(imm_a[AW-1:0])] : imm_a;
  assign val_b      = dec.mb ? lmem[wrap_local(imm_b[AW-1:0])] : imm_b;
  // One bit wider than ip so that running off the end of a full-size program is visible.
  assign next_ip    = {1'b0, ip_q} + (AW + 1)'(1);

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    steps_d    = steps_q;
    fin_d      = fin_q;
    succ_d     = succ_q;
    tmo_d      = tmo_q;
    clr_d      = clr_q;
    pmem_we    = 1'b0;
    lmem_we    = 1'b0;
    lmem_waddr = wrap_local(dec.t[AW-1:0]);
    lmem_wdata = val_a;
    fifo_push  = 1'b0;
    fifo_clr   = 1'b0;
    retire     = 1'b0;
    jump       = 1'b0;
    halt       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        pmem_we = load;
        if (run) begin
          state_d  = StClear;
          ip_d     = '0;
          steps_d  = '0;
          fin_d    = 1'b0;
          succ_d   = 1'b0;
          tmo_d    = 1'b0;
          clr_d    = '0;
          fifo_clr = 1'b1;
        end
      end
      StClear: begin
        lmem_we    = 1'b1;
        lmem_waddr = clr_q;
        lmem_wdata = '0;
        clr_d      = clr_q + 1'b1;
        if (clr_q == AW'(NLocal - 1)) state_d = StFetch;
      end
      StFetch: state_d = StExec;
      StExec: begin
        retire = 1'b1;
        case (dec.op)
          OpAdd: begin
            lmem_we    = 1'b1;
            lmem_wdata = val_a + val_b;
          end
          OpSub: begin
            lmem_we    = 1'b1;
            lmem_wdata = val_a - val_b;
          end
          OpMov: lmem_we = 1'b1;
          OpOut: begin
            // A full FIFO parks the instruction; it retires from STALL instead.
            if (fifo_full) begin
              retire  = 1'b0;
              state_d = StStall;
            end else begin
              fifo_push = 1'b1;
            end
          end
          OpJmp:  jump = 1'b1;
          OpJeq:  jump = (val_a == val_b);
          OpJlt:  jump = (val_a < val_b);
          OpHalt: halt = 1'b1;
          default: ;
        endcase
      end
      StStall: begin
        // instr_q is still the parked OUT, so val_a is the word to push.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          retire    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (retire) begin
      steps_d = steps_q + 32'd1;
      ip_d    = jump ? wrap_code(dec.t[AW-1:0]) : next_ip[AW-1:0];
      if (halt || (!jump && next_ip == (AW + 1)'(NCode))) begin
        state_d = StDone;
        fin_d   = 1'b1;
        succ_d  = 1'b1;
      end else if (steps_d == 32'(MaxSteps)) begin
        state_d = StDone;
        fin_d   = 1'b1;
        tmo_d   = 1'b1;
      end else begin
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ip_q    <= '0;
      clr_q   <= '0;
      steps_q <= '0;
      fin_q   <= 1'b0;
      succ_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      clr_q   <= clr_d;
      steps_q <= steps_d;
      fin_q   <= fin_d;
      succ_q  <= succ_d;
      tmo_q   <= tmo_d;
    end
  end

  // RAM-style storage: no reset, program memory survives reset and restarts.
  always_ff @(posedge clock) begin
    if (pmem_we) pmem[wrap_code(load_addr)] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (state_q == StFetch) instr_q <= pmem[ip_q];
  end

  always_ff @(posedge clock) begin
    if (lmem_we) lmem[lmem_waddr] <= lmem_wdata;
  end

  fpga_out_fifo #(
    .Width(Width),
    .Depth(NOut)
  ) u_out_fifo (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (fifo_clr),
    .push_i     (fifo_push),
    .wdata_i    (val_a),
    .full_o     (fifo_full),
    .out_valid_o(out_if.out_valid),
    .out_data_o (out_if.out_data),
    .out_ready_i(out_if.out_ready)
  );

  assign finished = fin_q;
  assign success  = succ_q;
  assign timeout  = tmo_q;
  assign ip       = ip_q;
  assign steps    = steps_q;

endmodule

// File: tb/tb_fpga_exec.sv
module tb_fpga_exec;

  localparam int unsigned W   = 12;
  localparam int unsigned NL  = 64;
  localparam int unsigned NC  = 64;
  localparam int unsigned NO  = 4;
  localparam int unsigned MS  = 40;
  localparam int unsigned AWT = 6;
  localparam int unsigned IW  = 4 + AWT + 2 * (1 + W);

  localparam logic [3:0] CAdd = 4'd0, CSub = 4'd1, COut = 4'd3, CJmp = 4'd4, CJlt = 4'd6,
                         CHalt = 4'd7;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           load = 1'b0;
  logic [AWT-1:0] load_addr = '0;
  logic [IW-1:0]  load_data = '0;
  logic           run = 1'b0;
  logic           finished, success, timeout;
  logic [AWT-1:0] ip;
  logic [31:0]    steps;

  fpga_exec_if #(.Width(W)) out_if ();

  fpga_exec #(
    .Width(W), .NLocal(NL), .NCode(NC), .NOut(NO), .MaxSteps(MS)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .load_addr(load_addr), .load_data(load_data),
    .run(run), .out_if(out_if), .finished(finished), .success(success), .timeout(timeout),
    .ip(ip), .steps(steps)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            failures = 0;
  int            ready_mode = 0;  // 0 low, 1 high, 2 random
  logic [IW-1:0] pm [NC];         // bench copy of what the program memory should hold
  logic [W-1:0]  exp_q [$];
  int            exp_steps;
  bit            exp_succ, exp_tmo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input int t, input bit ma,
                                       input int a, input bit mb, input int b);
    return {op, AWT'(t), ma, W'(a), mb, W'(b)};
  endfunction

  // Interpreter of the instruction set over plain arrays; queues expected out words.
  task automatic model_run(output int st, output bit succ, output bit tmo);
    logic [W-1:0]  lm [NL];
    logic [IW-1:0] w;
    logic [3:0]    op;
    logic [5:0]    t;
    logic [W-1:0]  a, b, va, vb;
    int            ipm, nip;
    bit            halt;
    foreach (lm[i]) lm[i] = '0;
    ipm = 0; st = 0; succ = 0; tmo = 0;
    forever begin
      w  = pm[ipm];
      op = w[35:32]; t = w[31:26]; a = w[24:13]; b = w[11:0];
      va = w[25] ? lm[a[5:0]] : a;
      vb = w[12] ? lm[b[5:0]] : b;
      nip  = ipm + 1;
      halt = 0;
      case (op)
        4'd0: lm[t] = va + vb;
        4'd1: lm[t] = va - vb;
        4'd2: lm[t] = va;
        4'd3: exp_q.push_back(va);
        4'd4: nip = int'(t) % NC;
        4'd5: if (va == vb) nip = int'(t) % NC;
        4'd6: if (va < vb) nip = int'(t) % NC;
        4'd7: halt = 1;
        default: ;
      endcase
      st++;
      if (halt || nip == NC) begin succ = 1; return; end
      if (st == MS) begin tmo = 1; return; end
      ipm = nip;
    end
  endtask

  task automatic do_load(input int addr, input logic [IW-1:0] w);
    @(posedge clock); #1;
    load = 1'b1; load_addr = AWT'(addr); load_data = w;
    @(posedge clock); #1;
    load = 1'b0;
    pm[addr] = w;
  endtask

  task automatic start_run();
    model_run(exp_steps, exp_succ, exp_tmo);
    @(posedge clock); #1 run = 1'b1;
    @(posedge clock); #1 run = 1'b0;
  endtask

  task automatic finish_check(input string name);
    int i;
    if (ready_mode == 0) ready_mode = 1;
    for (i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (finished) break;
    end
    if (i == 4000) begin
      checks++; failures++;
      $display("FAIL %s.wait_finished: got timeout expected finished", name);
    end
    for (i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !out_if.out_valid) break;
    end
    chk({name, ".pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, ".out_valid"}, 64'(out_if.out_valid), 64'd0);
    chk({name, ".finished"}, 64'(finished), 64'd1);
    chk({name, ".success"}, 64'(success), 64'(exp_succ));
    chk({name, ".timeout"}, 64'(timeout), 64'(exp_tmo));
    chk({name, ".steps"}, 64'(steps), 64'(exp_steps));
  endtask

  task automatic load_count_loop();
    do_load(0, mk(CAdd, 0, 0, 0, 0, 0));
    do_load(1, mk(COut, 0, 1, 0, 0, 0));
    do_load(2, mk(CAdd, 0, 1, 0, 0, 1));
    do_load(3, mk(CJlt, 1, 1, 0, 0, 10));
    do_load(4, mk(CHalt, 0, 0, 0, 0, 0));
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    fork
      forever begin  // out_ready driver
        @(posedge clock); #1;
        case (ready_mode)
          0: out_if.out_ready = 1'b0;
          1: out_if.out_ready = 1'b1;
          default: out_if.out_ready = 1'($urandom_range(0, 1));
        endcase
      end
      forever begin  // scoreboard monitor
        @(negedge clock);
        if (reset && out_if.out_valid && out_if.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL out_extra: got %0d expected no word", out_if.out_data);
          end else begin
            chk("out_data", 64'(out_if.out_data), 64'(exp_q.pop_front()));
          end
        end
      end
    join_none

    repeat (3) @(negedge clock);
    chk("rst.out_valid", 64'(out_if.out_valid), 64'd0);
    chk("rst.out_data", 64'(out_if.out_data), 64'd0);
    chk("rst.finished", 64'(finished), 64'd0);
    chk("rst.success", 64'(success), 64'd0);
    chk("rst.timeout", 64'(timeout), 64'd0);
    chk("rst.ip", 64'(ip), 64'd0);
    chk("rst.steps", 64'(steps), 64'd0);
    @(posedge clock); #1 reset = 1'b1;

    ready_mode = 1;
    for (int i = 0; i < int'(NC); i++) do_load(i, mk(CHalt, 0, 0, 0, 0, 0));

    // ADD / OUT / HALT
    do_load(0, mk(CAdd, 0, 0, 3, 0, 2));
    do_load(1, mk(COut, 0, 1, 0, 0, 0));
    do_load(2, mk(CHalt, 0, 0, 0, 0, 0));
    start_run();
    finish_check("add_out");

    // Count loop against a blocked consumer: stalls on the 5th OUT with NO words buffered
    load_count_loop();
    ready_mode = 0;
    start_run();
    repeat (150) @(negedge clock);
    chk("stall.steps", 64'(steps), 64'(1 + NO * 3));
    chk("stall.ip", 64'(ip), 64'd1);
    chk("stall.out_valid", 64'(out_if.out_valid), 64'd1);
    chk("stall.finished", 64'(finished), 64'd0);
    ready_mode = 1;
    finish_check("count");

    // Reset while stalled, then the same program again
    ready_mode = 0;
    start_run();
    repeat (150) @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("midrst.out_valid", 64'(out_if.out_valid), 64'd0);
    chk("midrst.ip", 64'(ip), 64'd0);
    chk("midrst.steps", 64'(steps), 64'd0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle.steps", 64'(steps), 64'd0);
    chk("idle.out_valid", 64'(out_if.out_valid), 64'd0);
    chk("idle.finished", 64'(finished), 64'd0);
    ready_mode = 2;
    start_run();
    finish_check("rerun");

    // Runaway self-loop
    do_load(0, mk(CJmp, 0, 0, 0, 0, 0));
    start_run();
    finish_check("selfloop");

    // Modular wrap: 0 - 1
    do_load(0, mk(CSub, 0, 0, 0, 0, 1));
    do_load(1, mk(COut, 0, 1, 0, 0, 0));
    do_load(2, mk(CHalt, 0, 0, 0, 0, 0));
    start_run();
    finish_check("wrap");

    // load/run mid-execution are ignored (not mirrored into pm)
    load_count_loop();
    ready_mode = 2;
    start_run();
    repeat (80) @(negedge clock);
    @(posedge clock); #1;
    load = 1'b1; run = 1'b1; load_addr = AWT'(3); load_data = mk(COut, 0, 0, 99, 0, 0);
    @(posedge clock); #1;
    load = 1'b0; run = 1'b0;
    finish_check("ignore");
    start_run();
    finish_check("ignore_rerun");

    // Random programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 12; i++) begin
        int  a, b;
        bit  ma, mb;
        ma = 1'($urandom_range(0, 1));
        mb = 1'($urandom_range(0, 1));
        a  = ma ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4095));
        b  = mb ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4095));
        do_load(i, mk(4'($urandom_range(0, 9)), int'($urandom_range(0, 11)), ma, a, mb, b));
      end
      start_run();
      finish_check($sformatf("rand%0d", p));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
